adc_scan_sequencer: RTL and testbench

Scan controller sitting between system logic and the 12-bit SPI ADC serial interface.
- On each sample tick it walks the enabled channels of an 8-channel ADC in ascending order.
- For each channel it issues one conversion request with the channel address, waits for completion and stores the 12-bit result in a per-channel result bank.
- Each stored result is announced with a tagged valid strobe. Results are also readable by address.

---
 rtl/adc_scan_sequencer.sv | 270 +++++++++++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_sequencer.sv
// ---------------------------------------------------------------------------
// adc_scan_sequencer
//
// Walks the enabled channels of an 8-channel SPI ADC once per sample tick.
// For each enabled channel (ascending order) it issues a conversion request,
// waits for the result (or abandons it after TIMEOUT cycles), stores the
// result in a per-channel bank and announces it with a tagged strobe.
//
// Ports
//   clk, rst_n     : clock, synchronous active-low reset
//   enable         : scanning enabled; tick generator runs only while high
//   chan_mask      : bit i includes channel i in the scan (latched per tick)
//   sample_div     : tick period minus 1 in clk cycles
//   clr_flags      : one-cycle pulse clearing overrun / timeout_err
//   conv_start     : one-cycle conversion request to the SPI interface
//   conv_addr      : channel address, stable from conv_start to conv_done
//   conv_done      : one-cycle completion pulse, conv_data valid with it
//   conv_data      : 12-bit conversion result
//   sample_valid   : one-cycle strobe, result just stored
//   sample_chan    : channel of sample_data
//   sample_data    : result just stored
//   scan_done      : one-cycle pulse at the end of every scan
//   rd_addr        : result bank read address
//   rd_data        : result[rd_addr], one cycle latency
//   busy           : high while a scan is in progress
//   overrun        : sticky, a tick arrived while a scan was in progress
//   timeout_err    : sticky, a conversion was abandoned
// ---------------------------------------------------------------------------
module adc_scan_sequencer #(
  parameter int DIV_W   = 16,
  parameter int TIMEOUT = 64,
  parameter int NCH     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [NCH-1:0]   chan_mask,
  input  logic [DIV_W-1:0] sample_div,
  input  logic             clr_flags,
  output logic             conv_start,
  output logic [2:0]       conv_addr,
  input  logic             conv_done,
  input  logic [11:0]      conv_data,
  output logic             sample_valid,
  output logic [2:0]       sample_chan,
  output logic [11:0]      sample_data,
  output logic             scan_done,
  input  logic [2:0]       rd_addr,
  output logic [11:0]      rd_data,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_FIND,
    S_START,
    S_WAIT_DONE,
    S_NEXT
  } state_t;

  state_t           state_reg;
  logic [NCH-1:0]   scan_mask_reg;
  logic [2:0]       ptr_reg;
  logic [TO_W-1:0]  to_cnt_reg;
  logic [DIV_W-1:0] tick_cnt_reg;
  logic             conv_start_reg;
  logic [2:0]       conv_addr_reg;
  logic             sample_valid_reg;
  logic [2:0]       sample_chan_reg;
  logic [11:0]      sample_data_reg;
  logic             scan_done_reg;
  logic             busy_reg;
  logic             overrun_reg;
  logic             timeout_err_reg;
  logic [11:0]      rd_data_reg;

  logic             tick;
  logic [NCH-1:0]   ge_mask;
  logic [NCH-1:0]   cand;
  logic             found;
  logic [2:0]       sel_ch;
  logic             store_en;
  logic [11:0]      bank_word [NCH];

  // -------------------------------------------------------------------------
  // Tick generator. The >= compare lets the counter recover at once if
  // sample_div is lowered below the current count.
  // -------------------------------------------------------------------------
  assign tick = enable && (tick_cnt_reg >= sample_div);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_reg <= '0;
    end else if (!enable || tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Next-channel finder: lowest set bit of the latched mask at or above ptr.
  // -------------------------------------------------------------------------
  assign ge_mask = {NCH{1'b1}} << ptr_reg;
  assign cand    = scan_mask_reg & ge_mask;

  always_comb begin
    found  = 1'b0;
    sel_ch = '0;
    // Descending walk so the lowest candidate is the last one written.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        found  = 1'b1;
        sel_ch = 3'(i);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Scan FSM with registered outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= S_IDLE;
      scan_mask_reg    <= '0;
      ptr_reg          <= '0;
      to_cnt_reg       <= '0;
      conv_start_reg   <= 1'b0;
      conv_addr_reg    <= '0;
      sample_valid_reg <= 1'b0;
      sample_chan_reg  <= '0;
      sample_data_reg  <= '0;
      scan_done_reg    <= 1'b0;
      busy_reg         <= 1'b0;
      overrun_reg      <= 1'b0;
      timeout_err_reg  <= 1'b0;
    end else begin
      conv_start_reg   <= 1'b0;
      sample_valid_reg <= 1'b0;
      scan_done_reg    <= 1'b0;

      // Clear first so that a set later in this block takes priority.
      if (clr_flags) begin
        overrun_reg     <= 1'b0;
        timeout_err_reg <= 1'b0;
      end

      if (tick && state_reg != S_IDLE && state_reg != S_WAIT_TICK) begin
        overrun_reg <= 1'b1;
      end

      case (state_reg)
        S_IDLE: begin
          if (enable) begin
            state_reg <= S_WAIT_TICK;
          end
        end

        S_WAIT_TICK: begin
          if (!enable) begin
            state_reg <= S_IDLE;
          end else if (tick) begin
            if (chan_mask == '0) begin
              scan_done_reg <= 1'b1;
            end else begin
              scan_mask_reg <= chan_mask;
              ptr_reg       <= '0;
              state_reg     <= S_FIND;
              busy_reg      <= 1'b1;
            end
          end
        end

        S_FIND: begin
          if (found) begin
            conv_addr_reg  <= sel_ch;
            conv_start_reg <= 1'b1;
            state_reg      <= S_START;
          end else begin
            scan_done_reg <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= enable ? S_WAIT_TICK : S_IDLE;
          end
        end

        S_START: begin
          to_cnt_reg <= '0;
          state_reg  <= S_WAIT_DONE;
        end

        S_WAIT_DONE: begin
          if (conv_done) begin
            sample_valid_reg <= 1'b1;
            sample_chan_reg  <= conv_addr_reg;
            sample_data_reg  <= conv_data;
            state_reg        <= S_NEXT;
          end else if (to_cnt_reg == TO_W'(TIMEOUT - 1)) begin
            timeout_err_reg <= 1'b1;
            state_reg       <= S_NEXT;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end

        S_NEXT: begin
          if (conv_addr_reg == 3'd7 || !enable) begin
            scan_done_reg <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= enable ? S_WAIT_TICK : S_IDLE;
          end else begin
            ptr_reg   <= conv_addr_reg + 3'd1;
            state_reg <= S_FIND;
          end
        end

        default: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Result bank: one register per channel so reset can clear every entry.
  // -------------------------------------------------------------------------
  assign store_en = (state_reg == S_WAIT_DONE) && conv_done;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_bank
      logic [11:0] value_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          value_reg <= '0;
        end else if (store_en && conv_addr_reg == 3'(gi)) begin
          value_reg <= conv_data;
        end
      end

      assign bank_word[gi] = value_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= bank_word[rd_addr];
    end
  end

  assign conv_start   = conv_start_reg;
  assign conv_addr    = conv_addr_reg;
  assign sample_valid = sample_valid_reg;
  assign sample_chan  = sample_chan_reg;
  assign sample_data  = sample_data_reg;
  assign scan_done    = scan_done_reg;
  assign rd_data      = rd_data_reg;
  assign busy         = busy_reg;
  assign overrun      = overrun_reg;
  assign timeout_err  = timeout_err_reg;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adc_scan_sequencer
//
// Self-checking bench for adc_scan_sequencer. A behavioural SPI responder
// answers each request with 12'h100 + channel after a fixed latency (or never,
// for channels in its silent mask). Expected requests and samples are pushed
// to queues as each scan is set up and popped as the DUT produces them.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adc_scan_sequencer;

  localparam int DIV_W   = 16;
  localparam int TIMEOUT = 64;
  localparam int NCH     = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [7:0]  chan_mask;
  logic [15:0] sample_div;
  logic        clr_flags;
  logic        conv_start;
  logic [2:0]  conv_addr;
  logic        conv_done;
  logic [11:0] conv_data;
  logic        sample_valid;
  logic [2:0]  sample_chan;
  logic [11:0] sample_data;
  logic        scan_done;
  logic [2:0]  rd_addr;
  logic [11:0] rd_data;
  logic        busy;
  logic        overrun;
  logic        timeout_err;

  always #5 clk = ~clk;

  adc_scan_sequencer #(.DIV_W(DIV_W), .TIMEOUT(TIMEOUT), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .chan_mask(chan_mask),
    .sample_div(sample_div), .clr_flags(clr_flags),
    .conv_start(conv_start), .conv_addr(conv_addr),
    .conv_done(conv_done), .conv_data(conv_data),
    .sample_valid(sample_valid), .sample_chan(sample_chan),
    .sample_data(sample_data), .scan_done(scan_done),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic [2:0]  ch;
    logic [11:0] data;
  } samp_t;

  typedef struct {
    logic [7:0] mask;
    logic [7:0] silent;
    int         n_conv;
    int         n_valid;
    logic       to_err;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_start = 0;
  int          n_valid = 0;
  int          n_done = 0;
  logic [2:0]  exp_conv [$];
  samp_t       exp_samp [$];
  logic [11:0] model [8];
  logic [7:0]  silent = 8'h00;
  int          resp_lat = 20;
  int          resp_cnt = 0;
  logic [2:0]  resp_ch = 3'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural SPI responder.
  initial begin
    conv_done = 1'b0;
    conv_data = 12'h000;
    forever begin
      @(negedge clk);
      conv_done = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          conv_done = 1'b1;
          conv_data = 12'h100 + 12'(resp_ch);
        end
      end
      if (conv_start === 1'b1 && !silent[conv_addr]) begin
        resp_ch  = conv_addr;
        resp_cnt = resp_lat;
      end
    end
  end

  // Monitor: compares every request and every stored sample against the queues.
  initial begin
    samp_t e;
    forever begin
      @(negedge clk);
      if (conv_start === 1'b1) begin
        n_start++;
        if (exp_conv.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL conv_start_unexpected: got addr %0d, required no request", conv_addr);
        end else begin
          check("conv_addr", 64'(conv_addr), 64'(exp_conv.pop_front()));
        end
      end
      if (sample_valid === 1'b1) begin
        n_valid++;
        $display("sample ch=%0d data=0x%03h t=%0d", sample_chan, sample_data, cyc);
        if (exp_samp.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sample_unexpected: got ch %0d data 0x%0h, required no sample",
                   sample_chan, sample_data);
        end else begin
          e = exp_samp.pop_front();
          check("sample_chan", 64'(sample_chan), 64'(e.ch));
          check("sample_data", 64'(sample_data), 64'(e.data));
        end
      end
      if (scan_done === 1'b1) n_done++;
    end
  end

  task automatic push_scan(input logic [7:0] m, input logic [7:0] sil);
    samp_t s;
    for (int ch = 0; ch < 8; ch++) begin
      if (m[ch]) begin
        exp_conv.push_back(3'(ch));
        if (!sil[ch]) begin
          s.ch   = 3'(ch);
          s.data = 12'h100 + 12'(ch);
          exp_samp.push_back(s);
          model[ch] = s.data;
        end
      end
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    enable    = 1'b0;
    clr_flags = 1'b0;
    rd_addr   = 3'd0;
    tick_n(2);
    check("reset_outputs", 64'({conv_start, conv_addr, sample_valid, sample_chan, sample_data,
                                scan_done, rd_data, busy, overrun, timeout_err}), 64'd0);
    exp_conv.delete();
    exp_samp.delete();
    for (int i = 0; i < 8; i++) model[i] = 12'h000;
    rst_n = 1'b1;
    tick_n(1);
  endtask

  task automatic wait_scan_done(input int budget, input string name);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (scan_done === 1'b1) break;
    end
    if (k == budget) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got no scan_done within %0d cycles, required scan_done", name, budget);
    end
  endtask

  task automatic wait_start(input logic [2:0] ch, input int budget, input string name, output int t);
    int k;
    t = 0;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (conv_start === 1'b1 && conv_addr == ch) break;
    end
    t = cyc;
    if (k == budget) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got no conv_start for ch %0d within %0d cycles, required one", name, ch, budget);
    end
  endtask

  task automatic check_drained(input string name);
    check({name, "_conv_queue"}, 64'(exp_conv.size()), 64'd0);
    check({name, "_samp_queue"}, 64'(exp_samp.size()), 64'd0);
  endtask

  task automatic check_bank(input string name);
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      @(negedge clk);
      check($sformatf("%s_bank%0d", name, a), 64'(rd_data), 64'(model[a]));
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs [6];
    int   s0, v0, d0, t0, t1;

    vecs[0] = '{mask: 8'hFF, silent: 8'h00, n_conv: 8, n_valid: 8, to_err: 1'b0};
    vecs[1] = '{mask: 8'hA4, silent: 8'h00, n_conv: 3, n_valid: 3, to_err: 1'b0};
    vecs[2] = '{mask: 8'h0F, silent: 8'h08, n_conv: 4, n_valid: 3, to_err: 1'b1};
    vecs[3] = '{mask: 8'h00, silent: 8'h00, n_conv: 0, n_valid: 0, to_err: 1'b0};
    vecs[4] = '{mask: 8'h81, silent: 8'h00, n_conv: 2, n_valid: 2, to_err: 1'b0};
    vecs[5] = '{mask: 8'h01, silent: 8'h01, n_conv: 1, n_valid: 0, to_err: 1'b1};

    chan_mask  = 8'h00;
    sample_div = 16'd999;

    // Table-driven single scans.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      silent     = vecs[v].silent;
      chan_mask  = vecs[v].mask;
      sample_div = 16'd999;
      s0 = n_start; v0 = n_valid; d0 = n_done;
      push_scan(vecs[v].mask, vecs[v].silent);
      enable = 1'b1;
      wait_scan_done(3000, $sformatf("vec%0d_scan_done", v));
      enable = 1'b0;
      tick_n(5);
      check($sformatf("vec%0d_n_conv", v), 64'(n_start - s0), 64'(vecs[v].n_conv));
      check($sformatf("vec%0d_n_valid", v), 64'(n_valid - v0), 64'(vecs[v].n_valid));
      check($sformatf("vec%0d_n_done", v), 64'(n_done - d0), 64'd1);
      check($sformatf("vec%0d_timeout_err", v), 64'(timeout_err), 64'(vecs[v].to_err));
      check($sformatf("vec%0d_busy", v), 64'(busy), 64'd0);
      check_drained($sformatf("vec%0d", v));
      check_bank($sformatf("vec%0d", v));
    end
    silent = 8'h00;

    // Full mask, two consecutive scans: scan starts 1000 cycles apart.
    do_reset();
    chan_mask = 8'hFF; sample_div = 16'd999;
    d0 = n_done;
    push_scan(8'hFF, 8'h00);
    push_scan(8'hFF, 8'h00);
    enable = 1'b1;
    wait_start(3'd0, 3000, "period_first_start", t0);
    wait_scan_done(1000, "period_scan1");
    wait_start(3'd0, 3000, "period_second_start", t1);
    check("period_scan_interval", 64'(t1 - t0), 64'd1000);
    wait_scan_done(1000, "period_scan2");
    enable = 1'b0;
    tick_n(5);
    check("period_n_done", 64'(n_done - d0), 64'd2);
    check_drained("period");

    // Overrun: tick period 11, each scan far longer.
    do_reset();
    chan_mask = 8'h03; sample_div = 16'd10;
    push_scan(8'h03, 8'h00);
    push_scan(8'h03, 8'h00);
    enable = 1'b1;
    wait_scan_done(500, "ovr_scan1");
    check("ovr_set", 64'(overrun), 64'd1);
    clr_flags = 1'b1;
    tick_n(1);
    clr_flags = 1'b0;
    check("ovr_cleared", 64'(overrun), 64'd0);
    wait_scan_done(500, "ovr_scan2");
    check("ovr_set_again", 64'(overrun), 64'd1);
    check("ovr_no_timeout", 64'(timeout_err), 64'd0);
    enable = 1'b0;
    tick_n(5);
    check_drained("ovr");

    // Timeout latency on a channel that never answers.
    do_reset();
    silent = 8'h08;
    chan_mask = 8'h0F; sample_div = 16'd999;
    push_scan(8'h0F, 8'h08);
    enable = 1'b1;
    wait_start(3'd3, 3000, "to_start_ch3", t0);
    t1 = t0;
    for (int k = 0; k < 200; k++) begin
      if (timeout_err === 1'b1) break;
      @(negedge clk);
      t1 = cyc;
    end
    n_vec++;
    if (!(t1 - t0 >= TIMEOUT && t1 - t0 <= TIMEOUT + 1)) begin
      n_err++;
      $display("FAIL to_latency: got %0d cycles, required %0d..%0d", t1 - t0, TIMEOUT, TIMEOUT + 1);
    end
    wait_scan_done(200, "to_scan_done");
    enable = 1'b0;
    silent = 8'h00;
    tick_n(5);
    check_drained("to");
    check_bank("to");

    // Enable dropped during the channel-1 conversion.
    do_reset();
    chan_mask = 8'hFF; sample_div = 16'd999;
    s0 = n_start; d0 = n_done;
    push_scan(8'h03, 8'h00);
    enable = 1'b1;
    wait_start(3'd1, 3000, "endrop_start_ch1", t0);
    tick_n(3);
    enable = 1'b0;
    wait_scan_done(200, "endrop_scan_done");
    check("endrop_busy", 64'(busy), 64'd0);
    tick_n(30);
    check("endrop_n_conv", 64'(n_start - s0), 64'd2);
    check("endrop_n_done", 64'(n_done - d0), 64'd1);
    check_drained("endrop");
    check_bank("endrop");

    // Reset in the middle of the channel-1 conversion; its late answer is ignored.
    do_reset();
    chan_mask = 8'hFF; sample_div = 16'd999;
    push_scan(8'h01, 8'h00);
    exp_conv.push_back(3'd1);
    enable = 1'b1;
    wait_start(3'd1, 3000, "rst_start_ch1", t0);
    tick_n(5);
    rst_n  = 1'b0;
    enable = 1'b0;
    tick_n(1);
    check("rst_mid_outputs", 64'({conv_start, conv_addr, sample_valid, sample_chan, sample_data,
                                  scan_done, rd_data, busy, overrun, timeout_err}), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = 12'h000;
    v0 = n_valid;
    tick_n(30);
    check("rst_late_done_ignored", 64'(n_valid - v0), 64'd0);
    check_drained("rst");
    check_bank("rst");

    // Empty mask: scan_done on each tick, no requests.
    do_reset();
    chan_mask = 8'h00; sample_div = 16'd9;
    s0 = n_start;
    enable = 1'b1;
    wait_scan_done(100, "empty_done1");
    t0 = cyc;
    wait_scan_done(100, "empty_done2");
    t1 = cyc;
    check("empty_done_interval", 64'(t1 - t0), 64'd10);
    enable = 1'b0;
    tick_n(3);
    check("empty_n_conv", 64'(n_start - s0), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
